// File: rtl/demux_behaviour.sv
// 1-to-4 registered demultiplexer.
// One input word plus a 2-bit select is steered into one of four single-entry
// holding registers. Each channel has its own valid/ready handshake, so a
// stalled consumer only back-pressures the words addressed to it.
module demux_behaviour #(
  parameter int DW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     y,
  input  logic [1:0]        s,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [4*DW-1:0]   i,
  output logic [3:0]        i_valid,
  input  logic [3:0]        i_ready,
  output logic [7:0]        xfer_cnt
);

  // Per-channel holding registers, valid flags and accepted-word counter.
  logic [3:0][DW-1:0] data_q;
  logic [3:0][DW-1:0] data_d;
  logic [3:0]         valid_q;
  logic [3:0]         valid_d;
  logic [7:0]         cnt_q;
  logic [7:0]         cnt_d;
  logic               accept;

  // Addressed channel can take a word if it is empty or being drained now.
  always_comb begin
    in_ready = ~valid_q[s] | i_ready[s];
    accept   = in_valid & in_ready;
  end

  // Next state: drain consumed channels, then load the selected one; a load
  // on the same edge as a drain keeps the channel full with the new word.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~i_ready;
    cnt_d   = cnt_q;
    if (accept) begin
      data_d[s]  = y;
      valid_d[s] = 1'b1;
      cnt_d      = cnt_q + 8'd1;
    end
  end

  // State registers; reset drops any pending words immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign i        = data_q;
  assign i_valid  = valid_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_demux_behaviour.sv
// Testbench for demux_behaviour: per-channel scoreboard queues filled on
// accepted input words and checked/popped as channels hold and drain them.
module tb_demux_behaviour;
  localparam int DW = 4;

  logic            clk;
  logic            rst;
  logic [DW-1:0]   y;
  logic [1:0]      s;
  logic            in_valid;
  logic            in_ready;
  logic [4*DW-1:0] i;
  logic [3:0]      i_valid;
  logic [3:0]      i_ready;
  logic [7:0]      xfer_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] sbq [4][$];
  logic [7:0]    exp_cnt = 8'd0;
  int            acc_total = 0;
  logic          last_acc = 1'b0;

  demux_behaviour #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .y(y), .s(s), .in_valid(in_valid),
    .in_ready(in_ready), .i(i), .i_valid(i_valid), .i_ready(i_ready),
    .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) sbq[k].delete();
    exp_cnt = 8'd0;
  endtask

  // Scoreboard monitor, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_rdy;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("valid%0d", k), {31'd0, i_valid[k]}, {31'd0, (sbq[k].size() != 0)});
        if (sbq[k].size() != 0)
          chk($sformatf("data%0d", k), {28'd0, i[k*DW +: DW]}, {28'd0, sbq[k][0]});
      end
      chk("cnt", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
      exp_rdy = (sbq[s].size() == 0) || i_ready[s];
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      for (int k = 0; k < 4; k++)
        if (sbq[k].size() != 0 && i_ready[k]) void'(sbq[k].pop_front());
      if (in_valid && exp_rdy) begin
        sbq[s].push_back(y);
        exp_cnt   = exp_cnt + 8'd1;
        acc_total = acc_total + 1;
        last_acc  = 1'b1;
      end else begin
        last_acc  = 1'b0;
      end
    end
  end

  initial begin
    int cycles;
    rst = 1'b1; y = '0; s = '0; in_valid = 1'b0; i_ready = 4'h0;
    #1;
    chk("rst_valid", {28'd0, i_valid}, 32'd0);
    chk("rst_data", {16'd0, i}, 32'd0);
    chk("rst_cnt", {24'd0, xfer_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step(); step();
    rst = 1'b0;
    step();

    // Single load into channel 2 with no consumer ready.
    y = 4'd5; s = 2'd2; in_valid = 1'b1; i_ready = 4'h0;
    step();
    in_valid = 1'b0;
    chk("t1_valid", {28'd0, i_valid}, 32'h4);
    chk("t1_data", {28'd0, i[11:8]}, 32'd5);
    chk("t1_cnt", {24'd0, xfer_cnt}, 32'd1);

    // Back-pressure on full channel 2, then accept on the draining edge.
    y = 4'd15; s = 2'd2; in_valid = 1'b1;
    #1 chk("t2_stall_rdy", {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t2_stall_cnt", {24'd0, xfer_cnt}, 32'd1);
      chk("t2_stall_data", {28'd0, i[11:8]}, 32'd5);
    end
    i_ready = 4'b0100;
    #1 chk("t2_rdy", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0; i_ready = 4'h0;
    chk("t2_valid2", {31'd0, i_valid[2]}, 32'd1);
    chk("t2_data", {28'd0, i[11:8]}, 32'd15);
    chk("t2_cnt", {24'd0, xfer_cnt}, 32'd2);

    // Full-throughput stream across all four channels.
    i_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      y = DW'(k + 1); s = 2'(k); in_valid = 1'b1;
      #1 chk("t3_rdy", {31'd0, in_ready}, 32'd1);
      step();
      chk("t3_valid", {28'd0, i_valid}, 32'(1 << k));
      chk("t3_data", {28'd0, i[k*DW +: DW]}, 32'(k + 1));
    end
    in_valid = 1'b0;
    step();
    chk("t3_empty", {28'd0, i_valid}, 32'd0);

    // Stalled channel 1 is untouched by a load to channel 3.
    i_ready = 4'h0; y = 4'd9; s = 2'd1; in_valid = 1'b1;
    step();
    y = 4'd6; s = 2'd3;
    #1 chk("t4_rdy", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("t4_valid", {28'd0, i_valid}, 32'hA);
    chk("t4_ch1", {28'd0, i[7:4]}, 32'd9);
    chk("t4_ch3", {28'd0, i[15:12]}, 32'd6);
    i_ready = 4'hF;
    step();

    // Counter wrap after 256 accepts from a fresh reset, random back-pressure.
    #1 rst = 1'b1; clear_model();
    step();
    rst = 1'b0; acc_total = 0; last_acc = 1'b1;
    cycles = 0;
    in_valid = 1'b1;
    while (acc_total < 256 && cycles < 4000) begin
      if (last_acc && acc_total < 256) begin
        y = DW'($urandom); s = 2'($urandom);
      end
      i_ready = 4'($urandom);
      step();
      cycles++;
      if (acc_total >= 256) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("wrap_accepts", acc_total, 32'd256);
    chk("wrap_cnt", {24'd0, xfer_cnt}, 32'd0);

    // Fill every channel, then reset asynchronously between edges.
    i_ready = 4'hF;
    step(); step();
    i_ready = 4'h0;
    for (int k = 0; k < 4; k++) begin
      y = DW'(k + 10); s = 2'(k); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("t5_full", {28'd0, i_valid}, 32'hF);
    #1 rst = 1'b1; clear_model();
    #1;
    chk("t5_rst_valid", {28'd0, i_valid}, 32'd0);
    chk("t5_rst_data", {16'd0, i}, 32'd0);
    chk("t5_rst_cnt", {24'd0, xfer_cnt}, 32'd0);
    chk("t5_rst_rdy", {31'd0, in_ready}, 32'd1);
    step();
    rst = 1'b0;
    step();
    chk("t5_post_cnt", {24'd0, xfer_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
